// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - command/response and SPI pin bundle for spi_master_ctrl
//
// Signals:
//   cmd_valid, cmd_type[1:0], cmd_data[7:0], cmd_ready : command handshake
//   ss_n, mosi, miso                                    : SPI pins
//   rsp_valid, rsp_data[7:0]                            : read response
//   busy                                                : master not idle
//   frame_cnt[15:0]                                     : completed frames (SPI_MASTER_FRAME_CNT_EN only)
// Modports: master = the SPI controller, slave = the requester / pin environment.
interface spi_master_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
`ifdef SPI_MASTER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    modport master (
        input  cmd_valid, cmd_type, cmd_data, miso,
        output cmd_ready, ss_n, mosi, rsp_valid, rsp_data, busy
`ifdef SPI_MASTER_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_data, miso,
        input  cmd_ready, ss_n, mosi, rsp_valid, rsp_data, busy
`ifdef SPI_MASTER_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master for the 10-bit command/data frame protocol
//
// Sends {cmd_type, cmd_data} MSB first on mosi while ss_n is low; for read-data
// commands (cmd_type 11) waits TURN_CYCLES then shifts in an 8-bit miso reply.
// Optional macro SPI_MASTER_FRAME_CNT_EN adds spi_bus.frame_cnt (saturating
// count of completed frames).
//
// Ports:
//   clk      in   system clock, posedge
//   rst      in   asynchronous active-high reset
//   spi_bus  master modport of spi_master_ctrl_if (command, SPI pins, response)
// Parameters:
//   TURN_CYCLES  0..15  ss_n-low idle cycles before the first miso sample
//   GAP_CYCLES   1..15  ss_n-high cycles after every frame
module spi_master_ctrl #(
    parameter int TURN_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_ctrl_if.master   spi_bus
);
    typedef enum logic [2:0] {IDLE, START, SHIFT, TURN, RECV, STOP} state_t;

    localparam logic [3:0] TURN_LAST = 4'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t     r_state;
    logic [9:0] r_frame;
    logic [7:0] r_rx;
    logic [3:0] r_cnt;
    logic       r_is_rd;
    logic       r_ss_n;
    logic       r_mosi;
    logic       r_cmd_ready;
    logic       r_busy;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_frame     <= '0;
            r_rx        <= '0;
            r_cnt       <= '0;
            r_is_rd     <= 1'b0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (spi_bus.cmd_valid && r_cmd_ready) begin
                        r_frame     <= {spi_bus.cmd_type, spi_bus.cmd_data};
                        r_is_rd     <= (spi_bus.cmd_type == 2'b11);
                        r_state     <= START;
                        r_ss_n      <= 1'b0;
                        r_mosi      <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                START: begin
                    // First bit goes out in the first SHIFT cycle.
                    r_state <= SHIFT;
                    r_mosi  <= r_frame[9];
                    r_frame <= {r_frame[8:0], 1'b0};
                    r_cnt   <= '0;
                end
                SHIFT: begin
                    if (r_cnt == 4'd9) begin
                        r_mosi <= 1'b0;
                        r_cnt  <= '0;
                        if (r_is_rd) begin
                            if (TURN_CYCLES > 0) r_state <= TURN;
                            else                 r_state <= RECV;
                        end else begin
                            r_state <= STOP;
                            r_ss_n  <= 1'b1;
                        end
                    end else begin
                        r_mosi  <= r_frame[9];
                        r_frame <= {r_frame[8:0], 1'b0};
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                TURN: begin
                    if (r_cnt == TURN_LAST) begin
                        r_state <= RECV;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RECV: begin
                    r_rx <= {r_rx[6:0], spi_bus.miso};
                    if (r_cnt == 4'd7) begin
                        // Publish the full byte including the bit sampled this edge.
                        r_rsp_data  <= {r_rx[6:0], spi_bus.miso};
                        r_rsp_valid <= 1'b1;
                        r_state     <= STOP;
                        r_ss_n      <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_ss_n      <= 1'b1;
                    r_mosi      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_cnt       <= '0;
                end
            endcase
        end
    end

    assign spi_bus.cmd_ready = r_cmd_ready;
    assign spi_bus.ss_n      = r_ss_n;
    assign spi_bus.mosi      = r_mosi;
    assign spi_bus.rsp_valid = r_rsp_valid;
    assign spi_bus.rsp_data  = r_rsp_data;
    assign spi_bus.busy      = r_busy;

`ifdef SPI_MASTER_FRAME_CNT_EN
    logic        w_stop_entry;
    logic [15:0] r_frame_cnt;

    assign w_stop_entry = ((r_state == SHIFT) && (r_cnt == 4'd9) && !r_is_rd) ||
                          ((r_state == RECV)  && (r_cnt == 4'd7));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_stop_entry && (r_frame_cnt != 16'hFFFF)) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign spi_bus.frame_cnt = r_frame_cnt;
`endif
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_ctrl_if if0();
    spi_master_ctrl_if if1();

    spi_master_ctrl #(.TURN_CYCLES(2), .GAP_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .spi_bus(if0)
    );
    spi_master_ctrl #(.TURN_CYCLES(0), .GAP_CYCLES(1)) u_dut_t0 (
        .clk(clk), .rst(rst), .spi_bus(if1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave + RAM model for if0: decodes frames from mosi, answers reads on miso.
    logic [7:0] ram [256];
    int         lc0 = 0;
    logic [9:0] sh0 = '0;
    logic [7:0] addr0 = '0;
    logic [7:0] rbyte0 = '0;
    always @(negedge clk) begin
        if (if0.ss_n) begin
            lc0 = 0;
            if0.miso = 1'b0;
        end else begin
            lc0++;
            if (lc0 >= 2 && lc0 <= 11) sh0 = {sh0[8:0], if0.mosi};
            if (lc0 == 11) begin
                case (sh0[9:8])
                    2'b00: addr0 = sh0[7:0];
                    2'b01: ram[addr0] = sh0[7:0];
                    2'b10: addr0 = sh0[7:0];
                    default: rbyte0 = ram[addr0];
                endcase
            end
            if (lc0 >= 14 && lc0 <= 21 && sh0[9:8] == 2'b11) if0.miso = rbyte0[21 - lc0];
            else                                             if0.miso = 1'b0;
        end
    end

    // if1 pin model: always returns 8'h81 right after the last mosi bit.
    int         lc1 = 0;
    logic [7:0] b81 = 8'h81;
    always @(negedge clk) begin
        if (if1.ss_n) begin
            lc1 = 0;
            if1.miso = 1'b0;
        end else begin
            lc1++;
            if (lc1 >= 12 && lc1 <= 19) if1.miso = b81[19 - lc1];
            else                        if1.miso = 1'b0;
        end
    end

    // Issue one command on if0 (called at a negedge) and observe the whole frame.
    task automatic run_cmd(input logic [1:0] t, input logic [7:0] d,
                           output int lowlen, output logic [9:0] word,
                           output int rcnt, output logic [7:0] rbyte, output int lat);
        int guard;
        lowlen = 0; word = '0; rcnt = 0; rbyte = '0; lat = 0; guard = 0;
        if0.cmd_type = t; if0.cmd_data = d; if0.cmd_valid = 1'b1;
        while (!if0.cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", (guard < 100), 1);
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                if0.cmd_valid = 1'b0;
                if0.cmd_type  = ~t;
                if0.cmd_data  = ~d;
            end
            if (!if0.ss_n) begin
                lowlen++;
                if (lowlen >= 2 && lowlen <= 11) word = {word[8:0], if0.mosi};
            end
            if (if0.rsp_valid) begin
                rcnt++;
                rbyte = if0.rsp_data;
            end
        end while (!if0.cmd_ready && lat < 100);
    endtask

    typedef struct {
        logic [1:0] t;
        logic [7:0] d;
        int         exp_low;
        logic [9:0] exp_word;
        int         exp_rcnt;
        logic [7:0] exp_rsp;
    } vec_t;

    vec_t vt [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowlen, rcnt, lat, acc, frames, mingap, hirun, guard;
        logic [9:0] word;
        logic [7:0] rbyte;
        logic prev_ss, saw_rsp;

        vt[0] = '{2'b00, 8'hA5, 11, 10'b00_1010_0101, 0, 8'h00};
        vt[1] = '{2'b00, 8'h10, 11, 10'b00_0001_0000, 0, 8'h00};
        vt[2] = '{2'b01, 8'h3C, 11, 10'b01_0011_1100, 0, 8'h00};
        vt[3] = '{2'b10, 8'h10, 11, 10'b10_0001_0000, 0, 8'h00};
        vt[4] = '{2'b11, 8'h00, 21, 10'b11_0000_0000, 1, 8'h3C};
        vt[5] = '{2'b00, 8'h55, 11, 10'b00_0101_0101, 0, 8'h00};
        vt[6] = '{2'b01, 8'hC3, 11, 10'b01_1100_0011, 0, 8'h00};
        vt[7] = '{2'b11, 8'hFF, 21, 10'b11_1111_1111, 1, 8'hC3};

        rst = 1'b1;
        if0.cmd_valid = 1'b0; if0.cmd_type = '0; if0.cmd_data = '0;
        if1.cmd_valid = 1'b0; if1.cmd_type = '0; if1.cmd_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ss_n", if0.ss_n, 1);
            chk("idle_mosi", if0.mosi, 0);
            chk("idle_cmd_ready", if0.cmd_ready, 1);
            chk("idle_rsp_valid", if0.rsp_valid, 0);
            chk("idle_busy", if0.busy, 0);
        end

        // Back-to-back wr-data with cmd_valid held high
        acc = 0; frames = 0; mingap = 99; hirun = 0; prev_ss = 1'b1; guard = 0;
        if0.cmd_type = 2'b01; if0.cmd_data = 8'h11; if0.cmd_valid = 1'b1;
        while (!(acc == 3 && if0.cmd_ready && !if0.cmd_valid) && guard < 200) begin
            if (if0.ss_n) begin
                hirun++;
            end else begin
                if (prev_ss) begin
                    if (frames > 0 && hirun < mingap) mingap = hirun;
                    frames++;
                end
                hirun = 0;
            end
            prev_ss = if0.ss_n;
            if (if0.cmd_valid && if0.cmd_ready) begin
                acc++;
                @(posedge clk);
                #1;
                if (acc == 3) if0.cmd_valid = 1'b0;
                else          if0.cmd_data = if0.cmd_data + 8'd1;
            end
            @(negedge clk);
            guard++;
        end
        chk("b2b_timeout", (guard < 200), 1);
        chk("b2b_accepts", acc, 3);
        chk("b2b_frames", frames, 3);
        chk("b2b_gap_ok", (mingap >= 1 && mingap < 99), 1);
`ifdef SPI_MASTER_FRAME_CNT_EN
        chk("frame_cnt", if0.frame_cnt, 3);
`endif

        // Table-driven frames through the slave + RAM model
        for (int i = 0; i < 8; i++) begin
            run_cmd(vt[i].t, vt[i].d, lowlen, word, rcnt, rbyte, lat);
            chk($sformatf("v%0d_ss_low", i), lowlen, vt[i].exp_low);
            chk($sformatf("v%0d_mosi", i), word, vt[i].exp_word);
            chk($sformatf("v%0d_rsp_cnt", i), rcnt, vt[i].exp_rcnt);
            chk($sformatf("v%0d_ready_lat", i), lat, vt[i].exp_low + 2);
            if (vt[i].exp_rcnt == 1) chk($sformatf("v%0d_rsp_data", i), rbyte, vt[i].exp_rsp);
        end

        // rsp_data holds across a non-read frame
        run_cmd(2'b00, 8'h01, lowlen, word, rcnt, rbyte, lat);
        chk("rsp_hold_cnt", rcnt, 0);
        chk("rsp_hold_data", if0.rsp_data, 8'hC3);

        // TURN_CYCLES=0 read on the second instance
        lowlen = 0; rcnt = 0; rbyte = '0; lat = 0;
        if1.cmd_type = 2'b11; if1.cmd_data = 8'h00; if1.cmd_valid = 1'b1;
        chk("t0_ready", if1.cmd_ready, 1);
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) if1.cmd_valid = 1'b0;
            if (!if1.ss_n) lowlen++;
            if (if1.rsp_valid) begin
                rcnt++;
                rbyte = if1.rsp_data;
            end
        end while (!if1.cmd_ready && lat < 100);
        chk("t0_ss_low", lowlen, 19);
        chk("t0_rsp_cnt", rcnt, 1);
        chk("t0_rsp_data", rbyte, 8'h81);
        chk("t0_ready_lat", lat, 21);

        // Reset during SHIFT bit 5 of a read-data frame
        if0.cmd_type = 2'b11; if0.cmd_data = 8'hE0; if0.cmd_valid = 1'b1;
        chk("abort_ready", if0.cmd_ready, 1);
        @(negedge clk);
        if0.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_pre_ss_n", if0.ss_n, 0);
        chk("abort_pre_mosi", if0.mosi, 1);
        rst = 1'b1;
        #1;
        chk("abort_ss_n", if0.ss_n, 1);
        chk("abort_mosi", if0.mosi, 0);
        chk("abort_busy", if0.busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", if0.cmd_ready, 1);
        saw_rsp = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (if0.rsp_valid || !if0.ss_n) saw_rsp = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_rsp", saw_rsp, 0);
`ifdef SPI_MASTER_FRAME_CNT_EN
        chk("abort_frame_cnt", if0.frame_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
